// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register indices and instruction codes used by
// decode, writeback and the register file.
package y86_pkg;

    localparam int unsigned REG_AW = 4;

    // Architectural register indices
    localparam logic [REG_AW-1:0] RRAX  = 4'h0;
    localparam logic [REG_AW-1:0] RRCX  = 4'h1;
    localparam logic [REG_AW-1:0] RRDX  = 4'h2;
    localparam logic [REG_AW-1:0] RRBX  = 4'h3;
    localparam logic [REG_AW-1:0] RRSP  = 4'h4;
    localparam logic [REG_AW-1:0] RRBP  = 4'h5;
    localparam logic [REG_AW-1:0] RRSI  = 4'h6;
    localparam logic [REG_AW-1:0] RRDI  = 4'h7;
    localparam logic [REG_AW-1:0] RR8   = 4'h8;
    localparam logic [REG_AW-1:0] RR9   = 4'h9;
    localparam logic [REG_AW-1:0] RR10  = 4'hA;
    localparam logic [REG_AW-1:0] RR11  = 4'hB;
    localparam logic [REG_AW-1:0] RR12  = 4'hC;
    localparam logic [REG_AW-1:0] RR13  = 4'hD;
    localparam logic [REG_AW-1:0] RR14  = 4'hE;
    localparam logic [REG_AW-1:0] RNONE = 4'hF;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/y86_scoreboard.sv
// Per-register busy scoreboard for the pipelined register file.
// Ports: clk/rst; srcA/srcB lookup -> busyA/busyB (registered bits only);
// iss_en/iss_dstE/iss_dstM claim; wb_en/dstE/dstM release; flush clears all.
module y86_scoreboard
    import y86_pkg::*;
#(
    parameter int unsigned NREGS = 15,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] srcA,
    input  logic [AW-1:0] srcB,
    output logic          busyA,
    output logic          busyB,
    input  logic          wb_en,
    input  logic [AW-1:0] dstE,
    input  logic [AW-1:0] dstM,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_dstE,
    input  logic [AW-1:0] iss_dstM,
    input  logic          flush
);

    localparam logic [AW-1:0] NREGS_IDX = AW'(NREGS);

    logic [NREGS-1:0] busy;

    // Flush beats issue beats writeback; indices >= NREGS (incl. RNONE) match no r
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (flush) begin
                    busy[r] <= 1'b0;
                end else if (iss_en && (iss_dstE == AW'(r) || iss_dstM == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (wb_en && (dstE == AW'(r) || dstM == AW'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Lookup of the stored bit; out-of-range and RNONE report not busy
    always_comb begin
        busyA = 1'b0;
        busyB = 1'b0;
        if (srcA < NREGS_IDX) busyA = busy[srcA];
        if (srcB < NREGS_IDX) busyB = busy[srcB];
    end

endmodule

// File: rtl/y86_regfile_pipe.sv
// Y86-64 register file: two bypassed combinational read ports, two write
// ports (E, M), busy scoreboard and an unbypassed debug read port.
// Ports: clk/rst; srcA/srcB -> valA/valB, busyA/busyB; wb_en, dstE/valE,
// dstM/valM write; iss_en/iss_dstE/iss_dstM claim; flush; dbg_sel -> dbg_val.
module y86_regfile_pipe
    import y86_pkg::*;
#(
    parameter int unsigned          XLEN     = 64,
    parameter int unsigned          NREGS    = 15,
    parameter int unsigned          AW       = 4,
    parameter logic [XLEN-1:0]      RSP_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   srcA,
    input  logic [AW-1:0]   srcB,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    output logic            busyA,
    output logic            busyB,
    input  logic            wb_en,
    input  logic [AW-1:0]   dstE,
    input  logic [XLEN-1:0] valE,
    input  logic [AW-1:0]   dstM,
    input  logic [XLEN-1:0] valM,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_dstE,
    input  logic [AW-1:0]   iss_dstM,
    input  logic            flush,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_val
);

    localparam logic [AW-1:0] NREGS_IDX = AW'(NREGS);
    localparam logic [AW-1:0] RSP_IDX   = AW'(RRSP);

    logic [XLEN-1:0] regs [NREGS];

    // Register array; M port wins when both ports target the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= (AW'(r) == RSP_IDX) ? RSP_INIT : '0;
            end
        end else if (wb_en) begin
            for (int r = 0; r < NREGS; r++) begin
                if (dstM == AW'(r)) begin
                    regs[r] <= valM;
                end else if (dstE == AW'(r)) begin
                    regs[r] <= valE;
                end
            end
        end
    end

    // Read ports with same-cycle writeback bypass, M before E
    always_comb begin
        valA = '0;
        if (srcA < NREGS_IDX) begin
            if (wb_en && srcA == dstM)      valA = valM;
            else if (wb_en && srcA == dstE) valA = valE;
            else                            valA = regs[srcA];
        end
    end

    always_comb begin
        valB = '0;
        if (srcB < NREGS_IDX) begin
            if (wb_en && srcB == dstM)      valB = valM;
            else if (wb_en && srcB == dstE) valB = valE;
            else                            valB = regs[srcB];
        end
    end

    // Debug port sees stored state only
    always_comb begin
        dbg_val = '0;
        if (dbg_sel < NREGS_IDX) dbg_val = regs[dbg_sel];
    end

    y86_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .busyA    (busyA),
        .busyB    (busyB),
        .wb_en    (wb_en),
        .dstE     (dstE),
        .dstM     (dstM),
        .iss_en   (iss_en),
        .iss_dstE (iss_dstE),
        .iss_dstM (iss_dstM),
        .flush    (flush)
    );

endmodule

// File: tb/tb_y86_regfile_pipe.sv
// Directed bench for y86_regfile_pipe: expected values are queued when the
// stimulus is driven and popped when the corresponding output is sampled.
module tb_y86_regfile_pipe;

    localparam int unsigned    XLEN  = 64;
    localparam int unsigned    NREGS = 14;
    localparam int unsigned    AW    = 4;
    localparam logic [63:0]    RSP   = 64'h0000_0000_0000_7FF0;
    localparam logic [AW-1:0]  RN    = 4'hF;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   srcA, srcB, dstE, dstM, iss_dstE, iss_dstM, dbg_sel;
    logic [XLEN-1:0] valA, valB, valE, valM, dbg_val;
    logic            busyA, busyB, wb_en, iss_en, flush;

    y86_regfile_pipe #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .AW       (AW),
        .RSP_INIT (RSP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .valA     (valA),
        .valB     (valB),
        .busyA    (busyA),
        .busyB    (busyB),
        .wb_en    (wb_en),
        .dstE     (dstE),
        .valE     (valE),
        .dstM     (dstM),
        .valM     (valM),
        .iss_en   (iss_en),
        .iss_dstE (iss_dstE),
        .iss_dstM (iss_dstM),
        .flush    (flush),
        .dbg_sel  (dbg_sel),
        .dbg_val  (dbg_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string tag, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t x;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
            return;
        end
        x = sb.pop_front();
        assert (obs === x.exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        wb_en = 1'b0; dstE = RN; dstM = RN; valE = '0; valM = '0;
        iss_en = 1'b0; iss_dstE = RN; iss_dstM = RN; flush = 1'b0;
    endtask

    task automatic dbg_check(input string tag, input logic [AW-1:0] idx, input logic [63:0] e);
        expect_val(tag, e);
        dbg_sel = idx;
        settle();
        check(dbg_val);
    endtask

    task automatic busy_check(input string tag, input logic [AW-1:0] idx, input logic e);
        expect_val(tag, {63'b0, e});
        srcA = idx;
        settle();
        check({63'b0, busyA});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        srcA = RN; srcB = RN; dbg_sel = '0;

        // Reset state
        settle();
        dbg_check("rst_r4", 4'h4, RSP);
        dbg_check("rst_r3", 4'h3, 64'h0);
        busy_check("rst_busy4", 4'h4, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-write aborts the write and clears busy
        wb_en = 1'b1; dstE = 4'h3; valE = 64'h33; iss_en = 1'b1; iss_dstE = 4'h9;
        tick();
        idle();
        dbg_check("pre_rst_r3", 4'h3, 64'h33);
        busy_check("pre_rst_busy9", 4'h9, 1'b1);
        wb_en = 1'b1; dstE = 4'h3; valE = 64'h44; iss_en = 1'b1; iss_dstM = 4'hA;
        settle();
        rst = 1'b1;
        dbg_check("async_rst_r3", 4'h3, 64'h0);
        dbg_check("async_rst_r4", 4'h4, RSP);
        busy_check("async_rst_busy9", 4'h9, 1'b0);
        tick();
        dbg_check("rst_edge_r3", 4'h3, 64'h0);
        busy_check("rst_edge_busy10", 4'hA, 1'b0);
        rst = 1'b0;
        idle();
        tick();

        // Write then read
        wb_en = 1'b1; dstE = 4'h2; valE = 64'h1122;
        tick();
        idle();
        srcA = 4'h2; srcB = RN;
        expect_val("read_r2", 64'h1122);
        expect_val("read_rnone", 64'h0);
        settle();
        check(valA);
        check(valB);

        // Bypass priority: M beats E
        wb_en = 1'b1; dstE = 4'h4; valE = 64'h10; dstM = 4'h4; valM = 64'h20;
        srcA = 4'h4; srcB = 4'h2;
        expect_val("bypass_m_over_e", 64'h20);
        expect_val("no_bypass_other", 64'h1122);
        settle();
        check(valA);
        check(valB);
        tick();
        idle();
        dbg_check("write_m_over_e", 4'h4, 64'h20);
        // wb_en=0: neither bypass nor write
        wb_en = 1'b0; dstE = 4'h4; valE = 64'h30; dstM = 4'h4; valM = 64'h40;
        srcA = 4'h4;
        expect_val("stall_no_bypass", 64'h20);
        settle();
        check(valA);
        tick();
        idle();
        dbg_check("stall_no_write", 4'h4, 64'h20);
        // E-only bypass
        wb_en = 1'b1; dstE = 4'h6; valE = 64'h66; srcA = 4'h6;
        expect_val("bypass_e", 64'h66);
        settle();
        check(valA);
        tick();
        idle();

        // Scoreboard set / clear / set beats clear
        iss_en = 1'b1; iss_dstE = 4'h5; srcA = 4'h5;
        expect_val("busy_no_same_cycle", 64'h0);
        settle();
        check({63'b0, busyA});
        tick();
        idle();
        busy_check("busy_set", 4'h5, 1'b1);
        wb_en = 1'b1; dstE = 4'h5; valE = 64'h55;
        expect_val("busy_during_wb", 64'h1);
        expect_val("bypass_during_busy", 64'h55);
        settle();
        check({63'b0, busyA});
        check(valA);
        tick();
        idle();
        busy_check("busy_cleared", 4'h5, 1'b0);
        iss_en = 1'b1; iss_dstE = 4'h5;
        tick();
        idle();
        wb_en = 1'b1; dstE = 4'h5; valE = 64'h57; iss_en = 1'b1; iss_dstM = 4'h5;
        tick();
        idle();
        busy_check("set_beats_clear", 4'h5, 1'b1);
        wb_en = 1'b1; dstM = 4'h5; valM = 64'h5A;
        tick();
        idle();
        busy_check("clear_via_m", 4'h5, 1'b0);
        dbg_check("r5_via_m", 4'h5, 64'h5A);

        // Flush clears everything and drops same-cycle issue
        iss_en = 1'b1; iss_dstE = 4'h1; iss_dstM = 4'h6;
        tick();
        iss_dstE = 4'h7; iss_dstM = RN;
        tick();
        idle();
        busy_check("pre_flush_1", 4'h1, 1'b1);
        busy_check("pre_flush_6", 4'h6, 1'b1);
        busy_check("pre_flush_7", 4'h7, 1'b1);
        flush = 1'b1; iss_en = 1'b1; iss_dstM = 4'h8;
        tick();
        idle();
        busy_check("flush_1", 4'h1, 1'b0);
        busy_check("flush_6", 4'h6, 1'b0);
        busy_check("flush_7", 4'h7, 1'b0);
        busy_check("flush_drops_8", 4'h8, 1'b0);

        // Bounds: index 14 is out of range with NREGS=14
        wb_en = 1'b1; dstE = 4'hE; valE = 64'hEE; dstM = 4'hD; valM = 64'hDD;
        srcA = 4'hE; srcB = 4'hD;
        expect_val("oob_read_zero", 64'h0);
        expect_val("bypass_last_reg", 64'hDD);
        settle();
        check(valA);
        check(valB);
        tick();
        idle();
        dbg_check("dbg_oob", 4'hE, 64'h0);
        dbg_check("dbg_rnone", 4'hF, 64'h0);
        dbg_check("r13_written", 4'hD, 64'hDD);
        dbg_check("r2_kept", 4'h2, 64'h1122);
        dbg_check("r4_kept", 4'h4, 64'h20);
        dbg_check("r6_kept", 4'h6, 64'h66);
        iss_en = 1'b1; iss_dstE = 4'hE;
        tick();
        idle();
        busy_check("oob_busy", 4'hE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
